// File: rtl/digit_entry_n_if.sv
// -----------------------------------------------------------------------------
// digit_entry_n_if
//   Keypad-side bundle for the N-digit code-entry register.
//   Button levels (debounced, clk-synchronous) flow from the keypad (master)
//   to the entry register (slave); the live digits, the selector and the
//   committed code snapshot flow back.
//
//   Signals
//     up, down, slide, slide_back, clear, enter : button levels
//     digits     [4*NUM_DIGITS-1:0] : live digit values, digit i at [4i+3:4i]
//     sel        [SEL_W-1:0]        : index of the selected digit
//     code_out   [4*NUM_DIGITS-1:0] : snapshot taken at the last commit
//     code_valid                    : one-cycle pulse when code_out updates
//
//   Modports
//     master : keypad / test driver side
//     slave  : digit_entry_n side
// -----------------------------------------------------------------------------
interface digit_entry_n_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SEL_W      = 2
);
  logic                    up;
  logic                    down;
  logic                    slide;
  logic                    slide_back;
  logic                    clear;
  logic                    enter;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [SEL_W-1:0]        sel;
  logic [4*NUM_DIGITS-1:0] code_out;
  logic                    code_valid;

  modport master (
    output up, down, slide, slide_back, clear, enter,
    input  digits, sel, code_out, code_valid
  );

  modport slave (
    input  up, down, slide, slide_back, clear, enter,
    output digits, sel, code_out, code_valid
  );
endinterface

// File: rtl/digit_entry_n.sv
// -----------------------------------------------------------------------------
// digit_entry_n
//   N-digit code-entry register for the safe keypad path. Debounced button
//   levels are turned into single-step edit events on a per-digit counter
//   array; enter publishes the entered code as a one-cycle-valid snapshot.
//
//   Optional feature macro: AUTO_REPEAT_EN
//     defined   : holding exactly one of up/down auto-repeats the step after
//                 REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
//     undefined : exactly one step per rising edge of up/down.
//
//   Ports
//     clk : system clock, rising edge
//     rst : asynchronous, active-high reset
//     kp  : digit_entry_n_if.slave (button levels in; digits, sel,
//           code_out, code_valid out)
//
//   Per-cycle priority (one action per cycle, losers are discarded):
//     clear > enter > slide/slide_back > up/down
// -----------------------------------------------------------------------------
module digit_entry_n #(
  parameter int NUM_DIGITS    = 4,
  parameter int DIGIT_MAX     = 9,
  parameter int SEL_W         = 2,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input logic            clk,
  input logic            rst,
  digit_entry_n_if.slave kp
);

  localparam logic [3:0]       DMAX    = 4'(DIGIT_MAX);
  localparam logic [SEL_W-1:0] SEL_TOP = SEL_W'(NUM_DIGITS - 1);

  // Button vector layout: {clear, enter, slide, slide_back, up, down}
  localparam int B_CLEAR = 5;
  localparam int B_ENTER = 4;
  localparam int B_SLIDE = 3;
  localparam int B_BACK  = 2;
  localparam int B_UP    = 1;
  localparam int B_DOWN  = 0;

  logic [5:0] btn_d, btn_q;     // edge history
  logic [5:0] ev;               // rising-edge events this cycle

  logic [SEL_W-1:0]        sel_d, sel_q;
  logic [4*NUM_DIGITS-1:0] code_d, code_q;
  logic                    code_valid_d, code_valid_q;
  logic [4*NUM_DIGITS-1:0] digits_flat;

  logic higher_ev;              // any event that outranks up/down
  logic edit_up, edit_down;     // accepted edge edits
  logic step_up, step_down;     // final step applied to the selected digit

  assign btn_d = {kp.clear, kp.enter, kp.slide, kp.slide_back, kp.up, kp.down};
  assign ev    = btn_d & ~btn_q;

  assign higher_ev = ev[B_CLEAR] | ev[B_ENTER] | ev[B_SLIDE] | ev[B_BACK];
  assign edit_up   = ~higher_ev & ev[B_UP]   & ~ev[B_DOWN];
  assign edit_down = ~higher_ev & ev[B_DOWN] & ~ev[B_UP];

`ifdef AUTO_REPEAT_EN
  logic [31:0] hold_cnt_d, hold_cnt_q;
  logic [31:0] hold_cnt_inc;
  logic        rep_armed_d, rep_armed_q;  // an up/down edge was accepted and is still held
  logic        rep_up_d, rep_up_q;        // 1: repeating up, 0: repeating down
  logic        hold_ok;
  logic        rep_fire;

  // The register holds the count of the previous held cycle, so the count of
  // the current cycle is hold_cnt_q+1; the press-edge cycle itself is count 0.
  always_comb begin
    hold_cnt_inc = hold_cnt_q + 32'd1;
    hold_ok      = rep_armed_q & ~higher_ev &
                   (rep_up_q ? (kp.up & ~kp.down) : (kp.down & ~kp.up));
    rep_fire     = 1'b0;
    hold_cnt_d   = 32'd0;
    rep_armed_d  = 1'b0;
    rep_up_d     = rep_up_q;
    if (edit_up & ~kp.down) begin
      rep_armed_d = 1'b1;
      rep_up_d    = 1'b1;
    end else if (edit_down & ~kp.up) begin
      rep_armed_d = 1'b1;
      rep_up_d    = 1'b0;
    end else if (hold_ok) begin
      rep_armed_d = 1'b1;
      if (hold_cnt_inc == 32'(REPEAT_DELAY)) begin
        rep_fire   = 1'b1;
        // Reload so the next step lands REPEAT_PERIOD cycles later.
        hold_cnt_d = 32'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
        hold_cnt_d = hold_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q  <= 32'd0;
      rep_armed_q <= 1'b0;
      rep_up_q    <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      rep_armed_q <= rep_armed_d;
      rep_up_q    <= rep_up_d;
    end
  end

  assign step_up   = edit_up   | (rep_fire &  rep_up_q);
  assign step_down = edit_down | (rep_fire & ~rep_up_q);
`else
  // Repeat timing is only meaningful with auto-repeat built in.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);

  assign step_up   = edit_up;
  assign step_down = edit_down;
`endif

  // Per-digit counters; only the selected digit ever steps.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] digit_d, digit_q;
      logic       is_sel;

      assign is_sel = (sel_q == SEL_W'(gi));

      always_comb begin
        digit_d = digit_q;
        if (ev[B_CLEAR]) begin
          digit_d = 4'd0;
        end else if (is_sel && step_up) begin
          digit_d = (digit_q == DMAX) ? 4'd0 : digit_q + 4'd1;
        end else if (is_sel && step_down) begin
          digit_d = (digit_q == 4'd0) ? DMAX : digit_q - 4'd1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) digit_q <= 4'd0;
        else     digit_q <= digit_d;
      end

      assign digits_flat[4*gi +: 4] = digit_q;
    end
  endgenerate

  always_comb begin
    sel_d = sel_q;
    if (ev[B_CLEAR]) begin
      sel_d = '0;
    end else if (!ev[B_ENTER]) begin
      // slide and slide_back together cancel out
      if (ev[B_SLIDE] && !ev[B_BACK]) begin
        sel_d = (sel_q == SEL_TOP) ? '0 : sel_q + SEL_W'(1);
      end else if (ev[B_BACK] && !ev[B_SLIDE]) begin
        sel_d = (sel_q == '0) ? SEL_TOP : sel_q - SEL_W'(1);
      end
    end
  end

  always_comb begin
    code_d       = code_q;
    code_valid_d = 1'b0;
    if (!ev[B_CLEAR] && ev[B_ENTER]) begin
      code_d       = digits_flat;
      code_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q        <= 6'd0;
      sel_q        <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
    end else begin
      btn_q        <= btn_d;
      sel_q        <= sel_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
    end
  end

  assign kp.digits     = digits_flat;
  assign kp.sel        = sel_q;
  assign kp.code_out   = code_q;
  assign kp.code_valid = code_valid_q;

endmodule

// File: tb/tb_digit_entry_n.sv
// -----------------------------------------------------------------------------
// tb_digit_entry_n
//   Bench for digit_entry_n (NUM_DIGITS=4, DIGIT_MAX=9, REPEAT_DELAY=8,
//   REPEAT_PERIOD=4). Each driven cycle updates a behavioural keypad model and
//   pushes the expected outputs; the test task pops and compares after the edge.
//   Works with or without AUTO_REPEAT_EN defined.
// -----------------------------------------------------------------------------
module tb_digit_entry_n;
  localparam int ND = 4;
  localparam int SW = 2;

  // Button vector layout: {clear, enter, slide, slide_back, up, down}
  localparam logic [5:0] B_NONE  = 6'b000000;
  localparam logic [5:0] B_CLEAR = 6'b100000;
  localparam logic [5:0] B_ENTER = 6'b010000;
  localparam logic [5:0] B_SLIDE = 6'b001000;
  localparam logic [5:0] B_BACK  = 6'b000100;
  localparam logic [5:0] B_UP    = 6'b000010;
  localparam logic [5:0] B_DOWN  = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  digit_entry_n_if #(.NUM_DIGITS(ND), .SEL_W(SW)) kp ();

  digit_entry_n #(
    .NUM_DIGITS(ND), .DIGIT_MAX(9), .SEL_W(SW),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  typedef struct {
    string       name;
    logic [15:0] digits;
    logic [1:0]  sel;
    logic [15:0] code;
    logic        cv;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural keypad model
  int         m_dig[ND];
  int         m_sel;
  logic [15:0] m_code;
  logic        m_cv;
  logic [5:0]  m_prev;

  function automatic logic [15:0] m_pack();
    logic [15:0] r;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(m_dig[i]);
    return r;
  endfunction

  function automatic logic [34:0] obs();
    return {kp.digits, kp.sel, kp.code_out, kp.code_valid};
  endfunction

  function automatic logic [34:0] pk(input exp_t e);
    return {e.digits, e.sel, e.code, e.cv};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_dig[i] = 0;
    m_sel  = 0;
    m_code = 16'h0;
    m_cv   = 1'b0;
    m_prev = 6'b0;
  endtask

  task automatic push(input string name);
    exp_t e;
    e.name   = name;
    e.digits = m_pack();
    e.sel    = 2'(m_sel);
    e.code   = m_code;
    e.cv     = m_cv;
    sb.push_back(e);
  endtask

  // Apply one cycle of button levels, predict the result, advance past the edge.
  task automatic drive(input logic [5:0] v, input string name);
    logic [5:0] ev;
    {kp.clear, kp.enter, kp.slide, kp.slide_back, kp.up, kp.down} = v;
    ev     = v & ~m_prev;
    m_prev = v;
    m_cv   = 1'b0;
    if (ev[5]) begin
      for (int i = 0; i < ND; i++) m_dig[i] = 0;
      m_sel = 0;
    end else if (ev[4]) begin
      m_code = m_pack();
      m_cv   = 1'b1;
    end else if (ev[3] | ev[2]) begin
      if (ev[3] && !ev[2])      m_sel = (m_sel == ND-1) ? 0 : m_sel + 1;
      else if (ev[2] && !ev[3]) m_sel = (m_sel == 0) ? ND-1 : m_sel - 1;
    end else if (ev[1] && !ev[0]) begin
      m_dig[m_sel] = (m_dig[m_sel] == 9) ? 0 : m_dig[m_sel] + 1;
    end else if (ev[0] && !ev[1]) begin
      m_dig[m_sel] = (m_dig[m_sel] == 0) ? 9 : m_dig[m_sel] - 1;
    end
    push(name);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    model_reset();
    {kp.clear, kp.enter, kp.slide, kp.slide_back, kp.up, kp.down} = B_NONE;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push("reset_hold");
    e = sb.pop_front();
    n_tests++;
    if (obs() !== pk(e)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), pk(e));
    end
    rst = 1'b0;
    drive(B_NONE, "reset_release");
    e = sb.pop_front();
    n_tests++;
    if (obs() !== pk(e)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), pk(e));
    end
  endtask

  task automatic test_up_down_wrap();
    exp_t e;
    logic [5:0] seq[$];
    seq = {B_CLEAR, B_NONE};
    for (int i = 0; i < 10; i++) begin
      seq.push_back(B_UP);
      seq.push_back(B_NONE);
    end
    seq.push_back(B_DOWN);   // 0 -> 9
    seq.push_back(B_NONE);
    foreach (seq[i]) begin
      drive(seq[i], "up_down_wrap");
      e = sb.pop_front();
      n_tests++;
      if (obs() !== pk(e)) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs(), pk(e));
      end
    end
    n_tests++;
    if (kp.digits[3:0] !== 4'd9) begin
      n_fail++;
      $display("FAIL down_from_zero: got %0d expected 9", kp.digits[3:0]);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    int   exp_d0;
    drive(B_CLEAR, "hold_clear");
    e = sb.pop_front();
    n_tests++;
    if (obs() !== pk(e)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), pk(e));
    end
    drive(B_NONE, "hold_idle");
    e = sb.pop_front();
    n_tests++;
    if (obs() !== pk(e)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), pk(e));
    end
    // up held for 20 clock edges starting from digit0 = 0
    kp.up = 1'b1;
    repeat (20) @(posedge clk);
    #1;
`ifdef AUTO_REPEAT_EN
    exp_d0 = 4;   // steps on cycles 0, 8, 12, 16
`else
    exp_d0 = 1;
`endif
    n_tests++;
    if (kp.digits[3:0] !== 4'(exp_d0)) begin
      n_fail++;
      $display("FAIL hold_up: digit0 got %0d expected %0d", kp.digits[3:0], exp_d0);
    end
    m_dig[0] = exp_d0;
    m_prev   = B_UP;
    drive(B_NONE, "hold_release");
    e = sb.pop_front();
    n_tests++;
    if (obs() !== pk(e)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), pk(e));
    end
  endtask

  task automatic test_slide();
    exp_t e;
    logic [5:0] seq[$];
    seq = {B_CLEAR, B_NONE, B_BACK, B_NONE};   // 0 -> 3
    for (int i = 0; i < 4; i++) begin
      seq.push_back(B_SLIDE);
      seq.push_back(B_NONE);
    end
    seq.push_back(B_SLIDE | B_BACK);           // cancels
    seq.push_back(B_NONE);
    foreach (seq[i]) begin
      drive(seq[i], "slide");
      e = sb.pop_front();
      n_tests++;
      if (obs() !== pk(e)) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs(), pk(e));
      end
    end
    n_tests++;
    if (kp.sel !== 2'd3) begin
      n_fail++;
      $display("FAIL slide_final: sel got %0d expected 3", kp.sel);
    end
  endtask

  task automatic test_commit();
    exp_t e;
    logic [5:0] seq[$];
    int ups[4] = '{3, 1, 4, 1};
    seq = {B_CLEAR, B_NONE};
    for (int d = 0; d < 4; d++) begin
      if (d != 0) begin
        seq.push_back(B_SLIDE);
        seq.push_back(B_NONE);
      end
      for (int k = 0; k < ups[d]; k++) begin
        seq.push_back(B_UP);
        seq.push_back(B_NONE);
      end
    end
    seq.push_back(B_ENTER);
    seq.push_back(B_NONE);
    seq.push_back(B_NONE);
    foreach (seq[i]) begin
      drive(seq[i], "commit");
      e = sb.pop_front();
      n_tests++;
      if (obs() !== pk(e)) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs(), pk(e));
      end
    end
    n_tests++;
    if (kp.code_out !== 16'h1413) begin
      n_fail++;
      $display("FAIL commit_code: got %h expected 1413", kp.code_out);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    logic [5:0] seq[$];
    seq = {B_UP, B_NONE,
           B_CLEAR | B_ENTER, B_NONE,       // clear wins, no commit
           B_UP, B_NONE,
           B_UP | B_DOWN, B_NONE,           // cancel
           B_SLIDE | B_UP, B_NONE,          // slide wins
           B_ENTER | B_SLIDE, B_NONE,       // enter wins
           B_ENTER, B_NONE};
    foreach (seq[i]) begin
      drive(seq[i], "priority");
      e = sb.pop_front();
      n_tests++;
      if (obs() !== pk(e)) begin
        n_fail++;
        $display("FAIL %s step %0d: got %h expected %h", e.name, i, obs(), pk(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drive(B_UP, "rst_mid_press");
    e = sb.pop_front();
    n_tests++;
    if (obs() !== pk(e)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), pk(e));
    end
    // Assert reset between edges with up still held: clears without a clock.
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    push("rst_mid_async");
    e = sb.pop_front();
    n_tests++;
    if (obs() !== pk(e)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), pk(e));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Held button re-fires once after release.
    drive(B_UP, "rst_mid_refire");
    e = sb.pop_front();
    n_tests++;
    if (obs() !== pk(e)) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), pk(e));
    end
    drive(B_NONE, "rst_mid_release");
    e = sb.pop_front();
    n_tests++;
    if (obs() !== pk(e) || kp.digits[3:0] !== 4'd1) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", e.name, obs(), pk(e));
    end
  endtask

  initial begin
    test_reset();
    test_up_down_wrap();
    test_hold();
    test_slide();
    test_commit();
    test_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
